mac_dot_sched: RTL and testbench

Shared dot-product scheduler for the Q7.9 multiply-accumulate datapath. Up to NREQ requesters submit dot-product jobs (two operand base addresses plus a length). The block arbitrates between them, fetches operand pairs from a single-port operand memory and runs the saturating Q7.9 MAC. It then returns one 16-bit result per job, tagged with the requester ID. It sits between the filter/compute engines and the shared operand RAM.

---
 rtl/mac_dot_sched.sv | 212 +++++++++++++++++++++
 tb/tb_mac_dot_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sched.sv
// mac_dot_sched: shared dot-product scheduler for the Q7.9 MAC datapath.
//
// Arbitrates between NREQ requesters, fetches A/B operand pairs from a
// single-port operand memory (one read per cycle, data one cycle later),
// accumulates rounded, saturated Q7.9 products and returns one 16-bit result
// per job tagged with the requester index.
//
// Optional feature: define MAC_DOT_SCHED_RR_EN for round-robin arbitration;
// otherwise the lowest-index valid requester wins (fixed priority).
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   req_valid/req_ready    per-requester job request / one-hot grant pulse
//   req_addr_a/req_addr_b  per-requester operand base addresses (slice i = req i)
//   req_len                per-requester element count
//   mem_rd_en/addr/data    operand memory read port (data valid 1 cycle later)
//   rsp_valid/rsp_ready    result handshake
//   rsp_id/rsp_data/rsp_sat  requester index, Q7.9 result, sticky saturation flag
module mac_dot_sched #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ADDR_W-1:0]     req_addr_a,
   input  logic [NREQ*ADDR_W-1:0]     req_addr_b,
   input  logic [NREQ*LEN_W-1:0]      req_len,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_rd_addr,
   input  logic [15:0]                mem_rd_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic [15:0]                rsp_data,
   output logic                       rsp_sat
);

   localparam int          IDW = $clog2(NREQ);
   localparam int unsigned NR  = NREQ;

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, ACC, DONE} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   addr_a, addr_b;
   logic [LEN_W-1:0]    len, k;
   logic [IDW-1:0]      id;
   logic [15:0]         acc, a_val;
   logic                sat;

   // per-requester field views
   logic [ADDR_W-1:0]   addr_a_arr [NREQ];
   logic [ADDR_W-1:0]   addr_b_arr [NREQ];
   logic [LEN_W-1:0]    len_arr    [NREQ];

   always_comb begin
      for (int unsigned i = 0; i < NR; i++) begin
         addr_a_arr[i] = req_addr_a[i*ADDR_W +: ADDR_W];
         addr_b_arr[i] = req_addr_b[i*ADDR_W +: ADDR_W];
         len_arr[i]    = req_len[i*LEN_W +: LEN_W];
      end
   end

   // ---------------- arbitration ----------------
   logic           gnt_any, grant;
   logic [IDW-1:0] gnt_idx;

`ifdef MAC_DOT_SCHED_RR_EN
   // rr_ptr holds the index where the next search begins (last grant + 1),
   // so a cleared pointer starts the first search at requester 0.
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] cand;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         cand = IDW'((32'(rr_ptr) + i) % NR);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (grant)
         rr_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
   end
`else
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (!gnt_any && req_valid[i]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'(i);
         end
      end
   end
`endif

   // no grant while rst is asserted, keeping every output at 0 during reset
   always_comb grant = (state == IDLE) && gnt_any && !rst;

   // ---------------- Q7.9 product and accumulate ----------------
   logic signed [31:0] a_ext, b_ext;
   logic [23:0]        ph;      // product bits [31:8]
   logic [16:0]        q_rnd, sum;
   logic [15:0]        q, acc_nx;
   logic               q_sat, acc_sat, top_ovf;

   always_comb begin
      a_ext   = 32'($signed(a_val));
      b_ext   = 32'($signed(mem_rd_data));
      ph      = 24'((a_ext * b_ext) >>> 8);
      top_ovf = (ph[23:16] != {8{ph[16]}});
      q_rnd   = {ph[16], ph[16:1]} + {16'd0, ph[0]};
      q_sat   = top_ovf || (q_rnd[16] != q_rnd[15]);
      q       = q_sat ? (ph[23] ? 16'h8000 : 16'h7FFF) : q_rnd[15:0];
      sum     = {acc[15], acc} + {q[15], q};
      acc_sat = (sum[16] != sum[15]);
      acc_nx  = acc_sat ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      req_ready   = '0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      rsp_valid   = 1'b0;
      rsp_id      = '0;
      rsp_data    = '0;
      rsp_sat     = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               req_ready = NREQ'(1) << gnt_idx;
               state_nx  = (len_arr[gnt_idx] == '0) ? DONE : RD_A;
            end
         end
         RD_A: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = addr_a + ADDR_W'(k);
            state_nx    = RD_B;
         end
         RD_B: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = addr_b + ADDR_W'(k);
            state_nx    = ACC;
         end
         ACC: begin
            state_nx = ((k + 1'b1) == len) ? DONE : RD_A;
         end
         DONE: begin
            rsp_valid = 1'b1;
            rsp_id    = id;
            rsp_data  = acc;
            rsp_sat   = sat;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a <= '0;
         addr_b <= '0;
         len    <= '0;
         id     <= '0;
         k      <= '0;
         acc    <= '0;
         sat    <= 1'b0;
         a_val  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  addr_a <= addr_a_arr[gnt_idx];
                  addr_b <= addr_b_arr[gnt_idx];
                  len    <= len_arr[gnt_idx];
                  id     <= gnt_idx;
                  k      <= '0;
                  acc    <= '0;
                  sat    <= 1'b0;
               end
            end
            RD_B: a_val <= mem_rd_data;
            ACC: begin
               acc <= acc_nx;
               sat <= sat | q_sat | acc_sat;
               k   <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_dot_sched.sv
// tb_mac_dot_sched: self-checking bench for mac_dot_sched.
// Expected grants, read addresses and responses are queued when a job is
// issued; a negedge monitor pops and compares as the DUT presents them.
module tb_mac_dot_sched;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 8;
   localparam int IDW    = 2;

   logic                   clk, rst;
   logic [NREQ-1:0]        req_valid, req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr_a, req_addr_b;
   logic [NREQ*LEN_W-1:0]  req_len;
   logic                   mem_rd_en;
   logic [ADDR_W-1:0]      mem_rd_addr;
   logic [15:0]            mem_rd_data;
   logic                   rsp_valid, rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [15:0]            rsp_data;
   logic                   rsp_sat;

   mac_dot_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_len(req_len),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_sat(rsp_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // operand memory: read data one cycle after the strobe
   logic [15:0] mem [1024];
   initial mem_rd_data = '0;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        sat;
      int          len;
   } rsp_t;

   rsp_t rsp_q[$];
   int   gnt_q[$];
   int   rd_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: plain integer arithmetic on the Q7.9 rules
   function automatic rsp_t model(input int id, input int aa, input int bb, input int len);
      rsp_t   r;
      longint acc = 0;
      bit     s   = 0;
      for (int k = 0; k < len; k++) begin
         longint a  = longint'($signed(mem[(aa + k) % 1024]));
         longint b  = longint'($signed(mem[(bb + k) % 1024]));
         longint p  = a * b;
         longint fl = p >>> 9;
         longint q;
         if (fl > 32767 || fl < -32768) begin
            q = (p < 0) ? -32768 : 32767;
            s = 1;
         end else begin
            q = (p + 256) >>> 9;
            if (q > 32767) begin q = 32767; s = 1; end
         end
         acc = acc + q;
         if (acc > 32767)       begin acc = 32767;  s = 1; end
         else if (acc < -32768) begin acc = -32768; s = 1; end
      end
      r.id   = id;
      r.data = 16'(acc);
      r.sat  = s;
      r.len  = len;
      return r;
   endfunction

   function automatic logic [15:0] rand_val();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom);
         1, 2:    return 16'($urandom_range(0, 4095) - 2048);
         default: begin
            case ($urandom_range(0, 3))
               0:       return 16'h7FFF;
               1:       return 16'h8000;
               2:       return 16'h0001;
               default: return 16'hFFFF;
            endcase
         end
      endcase
   endfunction

   task automatic push_job(input int id, input int aa, input int bb, input int len);
      gnt_q.push_back(id);
      rsp_q.push_back(model(id, aa, bb, len));
      for (int k = 0; k < len; k++) begin
         rd_q.push_back((aa + k) % 1024);
         rd_q.push_back((bb + k) % 1024);
      end
   endtask

   task automatic drive_req(input int id, input int aa, input int bb, input int len);
      req_addr_a[id*ADDR_W +: ADDR_W] = ADDR_W'(aa);
      req_addr_b[id*ADDR_W +: ADDR_W] = ADDR_W'(bb);
      req_len[id*LEN_W +: LEN_W]      = LEN_W'(len);
      req_valid[id]                   = 1'b1;
   endtask

   task automatic wait_grant(input int id);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[id] && n < 200);
      if (!req_ready[id]) chk("grant_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic issue(input int id, input int aa, input int bb, input int len);
      push_job(id, aa, bb, len);
      drive_req(id, aa, bb, len);
      wait_grant(id);
   endtask

   task automatic wait_idle(input bit bp);
      int n = 0;
      while ((rsp_q.size() != 0 || rd_q.size() != 0 || gnt_q.size() != 0) && n < 600) begin
         @(posedge clk); #1;
         if (bp) rsp_ready = 1'($urandom_range(0, 1));
         n++;
      end
      rsp_ready = 1'b1;
      if (rsp_q.size() != 0 || rd_q.size() != 0 || gnt_q.size() != 0) begin
         chk("idle_timeout", 64'(rsp_q.size()), 0);
         rsp_q.delete(); rd_q.delete(); gnt_q.delete();
      end
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_req_ready"},   64'(req_ready),   0);
      chk({tag, "_mem_rd_en"},   64'(mem_rd_en),   0);
      chk({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 0);
      chk({tag, "_rsp_valid"},   64'(rsp_valid),   0);
      chk({tag, "_rsp_id"},      64'(rsp_id),      0);
      chk({tag, "_rsp_data"},    64'(rsp_data),    0);
      chk({tag, "_rsp_sat"},     64'(rsp_sat),     0);
   endtask

   // ---------------- monitor ----------------
   int          grant_cyc = 0;
   int          g;
   int          ra;
   rsp_t        er;
   logic        prev_valid = 0, prev_ready = 0, prev_sat = 0;
   logic [15:0] prev_data = '0;
   logic [IDW-1:0] prev_id = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (req_ready != '0) begin
            if (gnt_q.size() == 0) chk("unexpected_grant", 64'(req_ready), 0);
            else begin
               g = gnt_q.pop_front();
               chk("grant", 64'(req_ready), 64'(1) << g);
            end
            grant_cyc = cyc;
         end
         if (mem_rd_en) begin
            if (rd_q.size() == 0) chk("unexpected_read", 64'(mem_rd_addr), 64'hFFFF);
            else begin
               ra = rd_q.pop_front();
               chk("rd_addr", 64'(mem_rd_addr), 64'(ra));
            end
         end
         if (rsp_valid && !prev_valid) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_data), 64'hFFFF);
            else chk("latency", 64'(cyc - grant_cyc), 64'(3 * rsp_q[0].len + 1));
         end
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", 64'(rsp_valid), 1);
            chk("hold_data",  64'(rsp_data),  64'(prev_data));
            chk("hold_id",    64'(rsp_id),    64'(prev_id));
            chk("hold_sat",   64'(rsp_sat),   64'(prev_sat));
         end
         if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
            er = rsp_q.pop_front();
            chk("rsp_id",   64'(rsp_id),   64'(er.id));
            chk("rsp_data", 64'(rsp_data), 64'(er.data));
            chk("rsp_sat",  64'(rsp_sat),  64'(er.sat));
         end
         prev_valid = rsp_valid;
         prev_ready = rsp_ready;
         prev_data  = rsp_data;
         prev_id    = rsp_id;
         prev_sat   = rsp_sat;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   int order[$];
   int cnt[NREQ];
   int remaining, n, gi;

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_addr_a = '0;
      req_addr_b = '0;
      req_len    = '0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = rand_val();

      repeat (3) @(posedge clk);
      #1;
      outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // arbitration: all requesters held valid, len 1 each
`ifdef MAC_DOT_SCHED_RR_EN
      order = '{0, 1, 2, 3, 0};
`else
      order = '{0, 0, 0, 1, 2, 3};
`endif
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      foreach (order[j]) begin
         cnt[order[j]]++;
         push_job(order[j], 'h100 + order[j], 'h110 + order[j], 1);
      end
      for (int i = 0; i < NREQ; i++) drive_req(i, 'h100 + i, 'h110 + i, 1);
      remaining = order.size();
      n = 0;
      while (remaining > 0 && n < 300) begin
         @(negedge clk);
         n++;
         if (req_ready != '0) begin
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
            cnt[gi]--;
            remaining--;
            @(posedge clk); #1;
            if (cnt[gi] <= 0) req_valid[gi] = 1'b0;
         end
      end
      if (remaining > 0) chk("arb_timeout", 64'(remaining), 0);
      req_valid = '0;
      wait_idle(0);

      // basic
      mem['h010] = 16'h0200; mem['h011] = 16'h0400;
      mem['h020] = 16'h0300; mem['h021] = 16'h0200;
      issue(0, 'h010, 'h020, 2); wait_idle(0);
      // rounding / sign
      mem['h030] = 16'h0001; mem['h040] = 16'h0100;
      issue(1, 'h030, 'h040, 1); wait_idle(0);
      mem['h031] = 16'hFE00; mem['h041] = 16'h0200;
      issue(2, 'h031, 'h041, 1); wait_idle(0);
      // saturation, positive and negative
      mem['h050] = 16'h7FFF; mem['h051] = 16'h7FFF;
      issue(3, 'h050, 'h050, 2); wait_idle(0);
      mem['h060] = 16'h8000; mem['h061] = 16'h8000;
      mem['h070] = 16'h7FFF; mem['h071] = 16'h7FFF;
      issue(0, 'h060, 'h070, 2); wait_idle(0);
      // zero length
      issue(1, 'h000, 'h000, 0); wait_idle(0);
      // address wrap
      issue(2, 'h3FF, 'h200, 2); wait_idle(0);

      // backpressure: response held, competing request not granted
      rsp_ready = 1'b0;
      issue(1, 'h010, 'h020, 2);
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
      chk("bp_rsp_seen", 64'(rsp_valid), 1);
      drive_req(2, 'h030, 'h040, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_no_grant", 64'(req_ready), 0);
         chk("bp_valid", 64'(rsp_valid), 1);
      end
      @(posedge clk); #1;
      push_job(2, 'h030, 'h040, 1);
      rsp_ready = 1'b1;
      wait_grant(2);
      wait_idle(0);

      // reset mid-job during RD_B
      issue(3, 'h010, 'h020, 2);   // returns in RD_A
      @(posedge clk); #1;          // now in RD_B
      chk("pre_rst_rd_en", 64'(mem_rd_en), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      outputs_zero("rst_mid");
      rsp_q.delete(); rd_q.delete(); gnt_q.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      issue(3, 'h010, 'h020, 2); wait_idle(0);

      // randomized single-requester jobs with random backpressure
      for (int j = 0; j < 60; j++) begin
         issue($urandom_range(0, NREQ-1), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 10));
         wait_idle(1);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
